// File: rtl/cci_mpf_prim_fifo_lutram_multi_pkg.sv
// Shared helpers for the multi-channel LUTRAM FIFO.
// Parameter-dependent types stay local to each module.
package cci_mpf_prim_fifo_lutram_multi_pkg;

    // Width of a tag that selects one of n items; never narrower than one bit.
    function automatic int tag_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cci_mpf_prim_fifo_lutram_multi_chan_ctrl.sv
// Per-channel FIFO bookkeeping: pointers, occupancy counter and registered
// flags derived from the next-state count.
module cci_mpf_prim_fifo_lutram_multi_chan_ctrl
  #(
    parameter int N_ENTRIES = 8,
    parameter int THRESHOLD = 2,
    localparam int IDX_W = $clog2(N_ENTRIES)
    )
   (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq_i,
    input  logic             deq_i,
    output logic [IDX_W-1:0] wr_idx_o,
    output logic [IDX_W-1:0] rd_idx_o,
    output logic             not_full_o,
    output logic             almost_full_o,
    output logic             not_empty_o
    );

    localparam int CNT_W = $clog2(N_ENTRIES + 1);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    idx_t wr_q, wr_d;
    idx_t rd_q, rd_d;
    cnt_t cnt_q, cnt_d;
    logic not_full_q, not_full_d;
    logic almost_full_q, almost_full_d;
    logic not_empty_q, not_empty_d;

    // N_ENTRIES is a power of two, so pointers wrap naturally at the index width.
    always_comb begin
        wr_d = enq_i ? wr_q + 1'b1 : wr_q;
        rd_d = deq_i ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + cnt_t'(enq_i) - cnt_t'(deq_i);
        not_full_d = (cnt_d != cnt_t'(N_ENTRIES));
        almost_full_d = (cnt_d >= cnt_t'(N_ENTRIES - THRESHOLD));
        not_empty_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            not_full_q <= 1'b1;
            almost_full_q <= 1'b0;
            not_empty_q <= 1'b0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
            not_full_q <= not_full_d;
            almost_full_q <= almost_full_d;
            not_empty_q <= not_empty_d;
        end
    end

    assign wr_idx_o = wr_q;
    assign rd_idx_o = rd_q;
    assign not_full_o = not_full_q;
    assign almost_full_o = almost_full_q;
    assign not_empty_o = not_empty_q;

endmodule

// File: rtl/cci_mpf_prim_lutram.sv
// Simple dual-port LUTRAM: registered write, asynchronous read.
// Contents are not reset.
module cci_mpf_prim_lutram
  #(
    parameter int N_ENTRIES   = 32,
    parameter int N_DATA_BITS = 32,
    localparam int AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
    )
   (
    input  logic                   clk,
    input  logic [AW-1:0]          raddr,
    output logic [N_DATA_BITS-1:0] rdata,
    input  logic [AW-1:0]          waddr,
    input  logic                   wen,
    input  logic [N_DATA_BITS-1:0] wdata
    );

    logic [N_DATA_BITS-1:0] mem [N_ENTRIES];

    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/cci_mpf_prim_fifo_lutram_multi.sv
// N_CHANNELS FIFOs sharing one LUTRAM, one tagged enqueue port and one
// round-robin arbitrated dequeue port.
module cci_mpf_prim_fifo_lutram_multi
    import cci_mpf_prim_fifo_lutram_multi_pkg::*;
  #(
    parameter int N_DATA_BITS = 32,
    parameter int N_CHANNELS  = 4,
    parameter int N_ENTRIES   = 8,
    parameter int THRESHOLD   = 2,
    localparam int TAG_W = tag_bits(N_CHANNELS)
    )
   (
    input  logic                   clk,
    input  logic                   reset,

    input  logic [N_DATA_BITS-1:0] enq_data,
    input  logic [TAG_W-1:0]       enq_chan,
    input  logic                   enq_en,
    output logic [N_CHANNELS-1:0]  notFull,
    output logic [N_CHANNELS-1:0]  almostFull,

    output logic [N_DATA_BITS-1:0] first,
    output logic [TAG_W-1:0]       first_chan,
    output logic                   notEmpty,
    input  logic                   deq_en
    );

    localparam int IDX_W     = $clog2(N_ENTRIES);
    localparam int RAM_DEPTH = N_CHANNELS * N_ENTRIES;
    localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] chan_t;

    logic [N_CHANNELS-1:0] chan_enq;
    logic [N_CHANNELS-1:0] chan_deq;
    logic [N_CHANNELS-1:0] chan_nf;
    logic [N_CHANNELS-1:0] chan_af;
    logic [N_CHANNELS-1:0] chan_ne;
    idx_t wr_idx [N_CHANNELS];
    idx_t rd_idx [N_CHANNELS];

    logic  enq_chan_ok;
    logic  wen;
    chan_t sel_chan;
    chan_t rr_q, rr_d;

    assign enq_chan_ok = (32'(enq_chan) < 32'(N_CHANNELS));
    // Shared storage: a write to a full channel would clobber its oldest entry.
    assign wen = enq_en && enq_chan_ok && chan_nf[enq_chan];

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
        assign chan_enq[g] = wen && (enq_chan == chan_t'(g));
        assign chan_deq[g] = deq_en && chan_ne[g] && (sel_chan == chan_t'(g));

        cci_mpf_prim_fifo_lutram_multi_chan_ctrl
          #(
            .N_ENTRIES(N_ENTRIES),
            .THRESHOLD(THRESHOLD)
            )
          ctrl
           (
            .clk(clk),
            .reset(reset),
            .enq_i(chan_enq[g]),
            .deq_i(chan_deq[g]),
            .wr_idx_o(wr_idx[g]),
            .rd_idx_o(rd_idx[g]),
            .not_full_o(chan_nf[g]),
            .almost_full_o(chan_af[g]),
            .not_empty_o(chan_ne[g])
            );
    end

    cci_mpf_prim_lutram
      #(
        .N_ENTRIES(RAM_DEPTH),
        .N_DATA_BITS(N_DATA_BITS)
        )
      storage
       (
        .clk(clk),
        .raddr(RAM_AW'({sel_chan, rd_idx[sel_chan]})),
        .rdata(first),
        .waddr(RAM_AW'({enq_chan, wr_idx[enq_chan]})),
        .wen(wen),
        .wdata(enq_data)
        );

    // Search cyclically from rr; falls back to rr when nothing is queued.
    always_comb begin
        int    c;
        chan_t c_t;
        logic  found;
        sel_chan = rr_q;
        found = 1'b0;
        c = 0;
        c_t = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            c = int'(rr_q) + i;
            if (c >= N_CHANNELS) c = c - N_CHANNELS;
            c_t = chan_t'(c);
            if (!found && chan_ne[c_t]) begin
                sel_chan = c_t;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (deq_en && notEmpty) begin
            rr_d = (sel_chan == chan_t'(N_CHANNELS - 1)) ? '0 : sel_chan + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign first_chan = sel_chan;
    assign notEmpty   = |chan_ne;
    assign notFull    = chan_nf;
    assign almostFull = chan_af;

    a_enq_chan_range: assert property (@(posedge clk) disable iff (reset)
        enq_en |-> enq_chan_ok)
        else $fatal(1, "enqueue to nonexistent channel");

    a_enq_full: assert property (@(posedge clk) disable iff (reset)
        (enq_en && enq_chan_ok) |-> chan_nf[enq_chan])
        else $fatal(1, "enqueue to full channel");

    a_deq_empty: assert property (@(posedge clk) disable iff (reset)
        deq_en |-> notEmpty)
        else $fatal(1, "dequeue with no channel non-empty");

endmodule

// File: tb/tb_cci_mpf_prim_fifo_lutram_multi.sv
// Directed self-checking bench for the multi-channel LUTRAM FIFO
// (4 channels x 8 entries, threshold 2).
module tb_cci_mpf_prim_fifo_lutram_multi;

  logic        clk;
  logic        reset;
  logic [31:0] enq_data;
  logic [1:0]  enq_chan;
  logic        enq_en;
  logic [3:0]  notFull;
  logic [3:0]  almostFull;
  logic [31:0] first;
  logic [1:0]  first_chan;
  logic        notEmpty;
  logic        deq_en;

  int n_cmp;
  int n_err;

  cci_mpf_prim_fifo_lutram_multi
    #(
      .N_DATA_BITS(32),
      .N_CHANNELS(4),
      .N_ENTRIES(8),
      .THRESHOLD(2)
      )
    dut
     (
      .clk(clk),
      .reset(reset),
      .enq_data(enq_data),
      .enq_chan(enq_chan),
      .enq_en(enq_en),
      .notFull(notFull),
      .almostFull(almostFull),
      .first(first),
      .first_chan(first_chan),
      .notEmpty(notEmpty),
      .deq_en(deq_en)
      );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; applies inputs across one posedge and returns at the next negedge.
  task automatic step(input logic e, input logic [1:0] ch, input logic [31:0] d, input logic q);
    enq_en = e;
    enq_chan = ch;
    enq_data = d;
    deq_en = q;
    @(posedge clk);
    @(negedge clk);
    enq_en = 1'b0;
    deq_en = 1'b0;
  endtask

  task automatic enq(input logic [1:0] ch, input logic [31:0] d);
    step(1'b1, ch, d, 1'b0);
  endtask

  task automatic deq_check(input string tag, input logic [1:0] ch, input logic [31:0] d);
    check({tag, "_ne"}, 32'(notEmpty), 32'd1);
    check({tag, "_chan"}, 32'(first_chan), 32'(ch));
    check({tag, "_data"}, first, d);
    step(1'b0, 2'd0, 32'd0, 1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    enq_en = 1'b0;
    enq_chan = 2'd0;
    enq_data = 32'd0;
    deq_en = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    check("rst_nf", 32'(notFull), 32'hf);
    check("rst_af", 32'(almostFull), 32'h0);
    check("rst_ne", 32'(notEmpty), 32'h0);
    check("rst_fc", 32'(first_chan), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Round-robin from rr=0
    enq(2'd0, 32'hA000_0000);
    check("rr_vis_ne", 32'(notEmpty), 32'd1);
    check("rr_vis_data", first, 32'hA000_0000);
    enq(2'd0, 32'hA000_0001);
    enq(2'd1, 32'hB000_0000);
    enq(2'd3, 32'hD000_0000);
    enq(2'd3, 32'hD000_0001);
    deq_check("rr0", 2'd0, 32'hA000_0000);
    deq_check("rr1", 2'd1, 32'hB000_0000);
    deq_check("rr2", 2'd3, 32'hD000_0000);
    deq_check("rr3", 2'd0, 32'hA000_0001);
    deq_check("rr4", 2'd3, 32'hD000_0001);
    check("rr_empty", 32'(notEmpty), 32'd0);
    check("rr_idle_chan", 32'(first_chan), 32'd0);

    // Single-channel fill/drain on ch2
    for (int i = 0; i < 8; i++) begin
      enq(2'd2, 32'(i));
      check($sformatf("fill_af_%0d", i + 1), 32'(almostFull), (i + 1 >= 6) ? 32'h4 : 32'h0);
      check($sformatf("fill_nf_%0d", i + 1), 32'(notFull), (i + 1 == 8) ? 32'hb : 32'hf);
      check($sformatf("fill_head_%0d", i + 1), first, 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      deq_check($sformatf("drain_%0d", i), 2'd2, 32'(i));
      check($sformatf("drain_nf_%0d", i), 32'(notFull), 32'hf);
      check($sformatf("drain_af_%0d", i), 32'(almostFull), (8 - (i + 1) >= 6) ? 32'h4 : 32'h0);
    end
    check("drain_ne", 32'(notEmpty), 32'd0);
    check("drain_idle_chan", 32'(first_chan), 32'd3);

    // Same-channel concurrent enq+deq on ch1 holding 3 entries
    enq(2'd1, 32'd100);
    enq(2'd1, 32'd101);
    enq(2'd1, 32'd102);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("same_chan_%0d", i), 32'(first_chan), 32'd1);
      check($sformatf("same_data_%0d", i), first, 32'(100 + i));
      step(1'b1, 2'd1, 32'(103 + i), 1'b1);
      check($sformatf("same_af_%0d", i), 32'(almostFull), 32'h0);
    end
    check("same_nf", 32'(notFull), 32'hf);
    deq_check("same_tail0", 2'd1, 32'd120);
    deq_check("same_tail1", 2'd1, 32'd121);
    deq_check("same_tail2", 2'd1, 32'd122);
    check("same_empty", 32'(notEmpty), 32'd0);

    // Cross-channel: enq ch3 while deq ch0
    for (int i = 0; i < 6; i++) enq(2'd3, 32'(400 + i));
    check("x_af6", 32'(almostFull), 32'h8);
    deq_check("x_pre", 2'd3, 32'd400);
    check("x_af5", 32'(almostFull), 32'h0);
    enq(2'd0, 32'd300);
    check("x_head0_chan", 32'(first_chan), 32'd0);
    check("x_head0_data", first, 32'd300);
    step(1'b1, 2'd3, 32'd406, 1'b1);
    check("x_af_after", 32'(almostFull), 32'h8);
    check("x_nf_after", 32'(notFull), 32'hf);
    for (int i = 0; i < 6; i++) begin
      deq_check($sformatf("x_drain_%0d", i), 2'd3, 32'(401 + i));
    end
    check("x_empty", 32'(notEmpty), 32'd0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 6; i++) enq(2'd2, 32'(600 + i));
    check("mid_pre_af", 32'(almostFull), 32'h4);
    check("mid_pre_chan", 32'(first_chan), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_nf", 32'(notFull), 32'hf);
    check("mid_rst_af", 32'(almostFull), 32'h0);
    check("mid_rst_ne", 32'(notEmpty), 32'h0);
    check("mid_rst_fc", 32'(first_chan), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ne", 32'(notEmpty), 32'd0);
    enq(2'd1, 32'h0000_0077);
    check("post_af", 32'(almostFull), 32'h0);
    deq_check("post_deq", 2'd1, 32'h0000_0077);
    check("post_empty", 32'(notEmpty), 32'd0);
    check("post_idle_chan", 32'(first_chan), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
